// File: rtl/divclk_tick_gen_pkg.sv
// Shared types and defaults for the divided-clock tick generator.
// Optional burst mode is enabled by defining DIVCLK_BURST_EN.
package divclk_pkg;

  typedef enum logic {
    DC_IDLE = 1'b0,
    DC_RUN  = 1'b1
  } dc_state_t;

  localparam int DC_WIDTH_DEF  = 16;
  localparam int DC_BCNT_W_DEF = 8;

endpackage

// File: rtl/divclk_tick_gen_if.sv
// Control/status bundle of the tick generator; burst_len exists only
// when DIVCLK_BURST_EN is defined.
interface divclk_tick_gen_if
  import divclk_pkg::*;
#(
  parameter int WIDTH  = DC_WIDTH_DEF,
  parameter int BCNT_W = DC_BCNT_W_DEF
);

  logic             start;
  logic             stop;
  logic             div_load;
  logic [WIDTH-1:0] div_val;
`ifdef DIVCLK_BURST_EN
  logic [BCNT_W-1:0] burst_len;
`endif
  logic             tick;
  logic             running;
  logic             done;

`ifdef DIVCLK_BURST_EN
  modport master (output start, stop, div_load, div_val, burst_len,
                  input  tick, running, done);
  modport slave  (input  start, stop, div_load, div_val, burst_len,
                  output tick, running, done);
`else
  modport master (output start, stop, div_load, div_val,
                  input  tick, running, done);
  modport slave  (input  start, stop, div_load, div_val,
                  output tick, running, done);
`endif

endinterface

// File: rtl/divclk_tick_gen_down_counter.sv
// Loadable down-counter that saturates at zero; tc flags the terminal count.
module divclk_down_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic [WIDTH-1:0] cnt,
  output logic             tc
);

  logic [WIDTH-1:0] cnt_r;

  // Count register: load has priority, decrement stops at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
    end else if (load) begin
      cnt_r <= load_val;
    end else if (en && (cnt_r != {WIDTH{1'b0}})) begin
      cnt_r <= cnt_r - {{(WIDTH-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign cnt = cnt_r;
  assign tc  = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: rtl/divclk_tick_gen.sv
// Tick generator for the divider toggle stage: one tick every div_act+1 cycles.
// Define DIVCLK_BURST_EN to end a run automatically after burst_len ticks.
module divclk_tick_gen
  import divclk_pkg::*;
#(
  parameter int               WIDTH   = DC_WIDTH_DEF,
  parameter logic [WIDTH-1:0] DIV_RST = {WIDTH{1'b0}},
  parameter int               BCNT_W  = DC_BCNT_W_DEF
) (
  input logic               clk,
  input logic               rst_n,
  divclk_tick_gen_if.slave  bus
);

  dc_state_t        state_r, state_nxt_s;
  logic [WIDTH-1:0] div_act_r, div_act_nxt_s;
  logic [WIDTH-1:0] div_shd_r, div_shd_nxt_s;
  logic [WIDTH-1:0] load_val_s, cnt_s;
  logic             cnt_load_s, cnt_en_s, tc_s;
  logic             tick_r, tick_nxt_s;
  logic             running_r;
  logic             done_r, done_nxt_s;
  logic             burst_end_s;

`ifdef DIVCLK_BURST_EN
  logic [BCNT_W-1:0] bcnt_r, bcnt_nxt_s;
  logic [BCNT_W-1:0] blen_r, blen_nxt_s;

  assign burst_end_s = (blen_r != {BCNT_W{1'b0}}) && (bcnt_r == blen_r);
`else
  assign burst_end_s = 1'b0;
`endif

  divclk_down_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load_s),
    .load_val (load_val_s),
    .en       (cnt_en_s),
    .cnt      (cnt_s),
    .tc       (tc_s)
  );

  // Next-state, divisor shadowing and output decode.
  always_comb begin
    state_nxt_s   = state_r;
    div_act_nxt_s = div_act_r;
    cnt_load_s    = 1'b0;
    cnt_en_s      = 1'b0;
    load_val_s    = div_act_r;
    tick_nxt_s    = 1'b0;
    done_nxt_s    = 1'b0;
`ifdef DIVCLK_BURST_EN
    bcnt_nxt_s    = bcnt_r;
    blen_nxt_s    = blen_r;
`endif
    if (bus.div_load) begin
      div_shd_nxt_s = bus.div_val;
    end else begin
      div_shd_nxt_s = div_shd_r;
    end

    case (state_r)
      DC_IDLE: begin
        if (bus.div_load) begin
          div_act_nxt_s = bus.div_val;
        end else begin
          div_act_nxt_s = div_act_r;
        end
        if (bus.start && !bus.stop) begin
          state_nxt_s = DC_RUN;
          cnt_load_s  = 1'b1;
          load_val_s  = div_act_nxt_s;
`ifdef DIVCLK_BURST_EN
          bcnt_nxt_s  = {BCNT_W{1'b0}};
          blen_nxt_s  = bus.burst_len;
`endif
        end else begin
          state_nxt_s = DC_IDLE;
        end
      end
      DC_RUN: begin
        cnt_en_s = 1'b1;
        if (bus.stop || burst_end_s) begin
          state_nxt_s = DC_IDLE;
          done_nxt_s  = 1'b1;
        end else if (tc_s) begin
          // Period boundary: the shadow divisor (including a same-cycle load) takes effect.
          tick_nxt_s    = 1'b1;
          cnt_load_s    = 1'b1;
          load_val_s    = div_shd_nxt_s;
          div_act_nxt_s = div_shd_nxt_s;
`ifdef DIVCLK_BURST_EN
          if (blen_r != {BCNT_W{1'b0}}) begin
            bcnt_nxt_s = bcnt_r + {{(BCNT_W-1){1'b0}}, 1'b1};
          end else begin
            bcnt_nxt_s = bcnt_r;
          end
`endif
        end else begin
          state_nxt_s = DC_RUN;
        end
      end
      default: begin
        state_nxt_s = DC_IDLE;
      end
    endcase
  end

  // State, divisor and registered output flops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= DC_IDLE;
      div_act_r <= DIV_RST;
      div_shd_r <= DIV_RST;
      tick_r    <= 1'b0;
      running_r <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      div_act_r <= div_act_nxt_s;
      div_shd_r <= div_shd_nxt_s;
      tick_r    <= tick_nxt_s;
      running_r <= (state_nxt_s == DC_RUN);
      done_r    <= done_nxt_s;
    end
  end

`ifdef DIVCLK_BURST_EN
  // Burst length capture and tick counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bcnt_r <= {BCNT_W{1'b0}};
      blen_r <= {BCNT_W{1'b0}};
    end else begin
      bcnt_r <= bcnt_nxt_s;
      blen_r <= blen_nxt_s;
    end
  end
`endif

  assign bus.tick    = tick_r;
  assign bus.running = running_r;
  assign bus.done    = done_r;

endmodule

// File: tb/tb_divclk_tick_gen.sv
// Directed bench for divclk_tick_gen: expected {tick,running,done} per cycle
// are queued with each stimulus step and checked one edge later.
module tb_divclk_tick_gen;

  logic clk;
  logic rst_n;

  divclk_tick_gen_if #(.WIDTH(16), .BCNT_W(8)) bus ();

  divclk_tick_gen #(.WIDTH(16), .DIV_RST(16'd0), .BCNT_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      tag;
    logic [2:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  test_cnt = 0;
  int  fail_cnt = 0;

  // Apply one cycle of stimulus, queue the expected outputs, check after the edge.
  task automatic cyc(input string tag, input logic st, input logic sp,
                     input logic ld, input logic [15:0] v, input logic [2:0] exp);
    sb_t        e;
    logic [2:0] obs;
    @(negedge clk);
    bus.start    = st;
    bus.stop     = sp;
    bus.div_load = ld;
    bus.div_val  = v;
    sb_q.push_back('{tag, exp});
    @(posedge clk);
    #1;
    e   = sb_q.pop_front();
    obs = {bus.tick, bus.running, bus.done};
    test_cnt++;
    assert (obs === e.exp) else begin
      fail_cnt++;
      $error("FAIL %s: observed tick/run/done=%b expected %b", e.tag, obs, e.exp);
    end
  endtask

  task automatic idle(input string tag, input logic [2:0] exp);
    cyc(tag, 1'b0, 1'b0, 1'b0, 16'd0, exp);
  endtask

  // d cycles without a tick followed by the tick cycle, repeated reps times.
  task automatic periods(input string tag, input int d, input int reps);
    for (int r = 0; r < reps; r++) begin
      for (int k = 0; k < d; k++) idle(tag, 3'b010);
      idle(tag, 3'b110);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.div_load = 1'b0;
    bus.div_val  = 16'd0;
`ifdef DIVCLK_BURST_EN
    bus.burst_len = 8'd0;
`endif

    // 1: reset, div=3, tick every 4 cycles; start during RUN is ignored
    idle("reset", 3'b000);
    idle("reset", 3'b000);
    rst_n = 1'b1;
    cyc("t1_load", 1'b0, 1'b0, 1'b1, 16'd3, 3'b000);
    cyc("t1_start", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    periods("t1_first", 3, 1);
    periods("t1_period", 3, 1);
    cyc("t4_start_in_run", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    idle("t4_period", 3'b010);
    idle("t4_period", 3'b010);
    idle("t4_period", 3'b110);
    periods("t1_period", 3, 1);
    cyc("t1_stop", 1'b0, 1'b1, 1'b0, 16'd0, 3'b001);
    idle("t1_after_stop", 3'b000);

    // 2: div=0 ticks every cycle, stop clears tick next cycle
    cyc("t2_load", 1'b0, 1'b0, 1'b1, 16'd0, 3'b000);
    cyc("t2_start", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    periods("t2_every", 0, 4);
    cyc("t2_stop", 1'b0, 1'b1, 1'b0, 16'd0, 3'b001);
    idle("t2_done_once", 3'b000);
    idle("t2_idle", 3'b000);

    // 3: div=4 then load div=1 mid-period; the running period completes
    cyc("t3_load4", 1'b0, 1'b0, 1'b1, 16'd4, 3'b000);
    cyc("t3_start", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    periods("t3_div4", 4, 1);
    cyc("t3_load1", 1'b0, 1'b0, 1'b1, 16'd1, 3'b010);
    idle("t3_finish5", 3'b010);
    idle("t3_finish5", 3'b010);
    idle("t3_finish5", 3'b010);
    idle("t3_finish5", 3'b110);
    periods("t3_div1", 1, 3);
    cyc("t3_stop", 1'b0, 1'b1, 1'b0, 16'd0, 3'b001);
    idle("t3_idle", 3'b000);

    // 4: start and stop together in IDLE is a no-op
    cyc("t4_start_stop", 1'b1, 1'b1, 1'b0, 16'd0, 3'b000);
    idle("t4_no_done", 3'b000);
    idle("t4_no_tick", 3'b000);

    // 5: reset mid-period, then divisor is back to DIV_RST (0)
    cyc("t5_load2", 1'b0, 1'b0, 1'b1, 16'd2, 3'b000);
    cyc("t5_start", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    idle("t5_mid", 3'b010);
    rst_n = 1'b0;
    idle("t5_reset", 3'b000);
    rst_n = 1'b1;
    idle("t5_post_reset", 3'b000);
    cyc("t5_restart", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    periods("t5_div_rst", 0, 3);
    cyc("t5_stop", 1'b0, 1'b1, 1'b0, 16'd0, 3'b001);
    idle("t5_idle", 3'b000);

`ifdef DIVCLK_BURST_EN
    // 6: burst of 3 ticks at div=2, then free-run with burst_len=0
    cyc("t6_load2", 1'b0, 1'b0, 1'b1, 16'd2, 3'b000);
    bus.burst_len = 8'd3;
    cyc("t6_start", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    bus.burst_len = 8'd0;
    periods("t6_burst", 2, 3);
    idle("t6_burst_done", 3'b001);
    idle("t6_burst_idle", 3'b000);
    cyc("t6_free_start", 1'b1, 1'b0, 1'b0, 16'd0, 3'b010);
    periods("t6_free", 2, 5);
    cyc("t6_free_stop", 1'b0, 1'b1, 1'b0, 16'd0, 3'b001);
    idle("t6_free_idle", 3'b000);
`endif

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end

endmodule
